// File: rtl/dominos_inputs_if.sv
// Input/output bundle between the hps_io key/joystick words and the Dominos cabinet pins.
// The master drives the raw HPS words; the slave (the front end) returns active-low controls.
interface dominos_inputs_if;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        coin1_n;
    logic        coin2_n;
    logic        start1_n;
    logic        start2_n;
    logic        up1_n;
    logic        down1_n;
    logic        left1_n;
    logic        right1_n;
    logic        up2_n;
    logic        down2_n;
    logic        left2_n;
    logic        right2_n;

    modport master (
        output ps2_key, joystick_0, joystick_1,
        input  coin1_n, coin2_n, start1_n, start2_n,
               up1_n, down1_n, left1_n, right1_n,
               up2_n, down2_n, left2_n, right2_n
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1,
        output coin1_n, coin2_n, start1_n, start2_n,
               up1_n, down1_n, left1_n, right1_n,
               up2_n, down2_n, left2_n, right2_n
    );
endinterface

// File: rtl/dominos_inputs.sv
// Player-input front end for the Dominos core: PS/2 key state, joystick merge,
// direction lockout and fixed-length coin pulses, all as registered active-low pins.
module dominos_inputs #(
    parameter int unsigned COIN_PULSE_CYCLES = 120000,
    parameter int unsigned CNT_W             = 17
) (
    input  logic            clk_sys,
    input  logic            reset,
    dominos_inputs_if.slave bus
);
    typedef enum logic [3:0] {
        K_UP1, K_DOWN1, K_LEFT1, K_RIGHT1,
        K_COIN1_A, K_COIN1_B, K_COIN2_A, K_COIN2_B,
        K_START1_A, K_START1_B, K_START2_A, K_START2_B,
        K_UP2, K_DOWN2, K_LEFT2, K_RIGHT2
    } key_e;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYCLES);

    logic             tog_q;
    logic             armed_q;
    logic             key_event;
    logic [15:0]      key_sel;
    logic [15:0]      key_q;
    logic [6:0]       jq0;
    logic [6:0]       jq1;
    logic             unused_joy_bits;

    logic             up1, down1, left1, right1;
    logic             up2, down2, left2, right2;
    logic             start1, start2;
    logic [1:0]       coin_req;
    logic [1:0]       req_q;
    logic [1:0]       coin_n_q;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [9:0]       level_n_q;

    assign unused_joy_bits = ^{bus.joystick_0[15:7], bus.joystick_1[15:7]};

    // The armed flag swallows the first post-reset cycle so a stale toggle level is not a key.
    assign key_event = armed_q && (bus.ps2_key[10] != tog_q);

    always_comb begin
        // NOTE: defaulting key_sel first keeps unlisted codes inert and avoids an inferred latch.
        key_sel = '0;
        case (bus.ps2_key[7:0])
            8'h75:   key_sel[K_UP1]    = 1'b1;
            8'h72:   key_sel[K_DOWN1]  = 1'b1;
            8'h6B:   key_sel[K_LEFT1]  = 1'b1;
            8'h74:   key_sel[K_RIGHT1] = 1'b1;
            default: ;
        endcase
        if (!bus.ps2_key[8]) begin
            case (bus.ps2_key[7:0])
                8'h29:   key_sel[K_COIN1_A]  = 1'b1;
                8'h2E:   key_sel[K_COIN1_B]  = 1'b1;
                8'h14:   key_sel[K_COIN2_A]  = 1'b1;
                8'h36:   key_sel[K_COIN2_B]  = 1'b1;
                8'h16:   key_sel[K_START1_A] = 1'b1;
                8'h05:   key_sel[K_START1_B] = 1'b1;
                8'h1E:   key_sel[K_START2_A] = 1'b1;
                8'h06:   key_sel[K_START2_B] = 1'b1;
                8'h2D:   key_sel[K_UP2]      = 1'b1;
                8'h2B:   key_sel[K_DOWN2]    = 1'b1;
                8'h23:   key_sel[K_LEFT2]    = 1'b1;
                8'h34:   key_sel[K_RIGHT2]   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            key_q   <= '0;
            jq0     <= '0;
            jq1     <= '0;
        end else begin
            // NOTE: non-blocking so every flop here samples pre-edge values regardless of order.
            tog_q   <= bus.ps2_key[10];
            armed_q <= 1'b1;
            jq0     <= bus.joystick_0[6:0];
            jq1     <= bus.joystick_1[6:0];
            if (key_event) begin
                key_q <= (key_q & ~key_sel) | (key_sel & {16{bus.ps2_key[9]}});
            end
        end
    end

    assign up1    = key_q[K_UP1]    | jq0[3];
    assign down1  = key_q[K_DOWN1]  | jq0[2];
    assign left1  = key_q[K_LEFT1]  | jq0[1];
    assign right1 = key_q[K_RIGHT1] | jq0[0];
    assign up2    = key_q[K_UP2]    | jq1[3];
    assign down2  = key_q[K_DOWN2]  | jq1[2];
    assign left2  = key_q[K_LEFT2]  | jq1[1];
    assign right2 = key_q[K_RIGHT2] | jq1[0];
    assign start1 = key_q[K_START1_A] | key_q[K_START1_B] | jq0[5] | jq1[5];
    assign start2 = key_q[K_START2_A] | key_q[K_START2_B] | jq0[6] | jq1[6];
    assign coin_req[0] = key_q[K_COIN1_A] | key_q[K_COIN1_B] | jq0[4];
    assign coin_req[1] = key_q[K_COIN2_A] | key_q[K_COIN2_B] | jq1[4];

    // Opposing directions cancel each other so the core never sees both asserted.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            level_n_q <= '1;
        end else begin
            level_n_q <= ~{start1, start2,
                           up1 & ~down1, down1 & ~up1, left1 & ~right1, right1 & ~left1,
                           up2 & ~down2, down2 & ~up2, left2 & ~right2, right2 & ~left2};
        end
    end

    // Coin pulse: a rising request edge loads the counter only when idle; busy edges are dropped.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_q    <= '0;
            coin_n_q <= '1;
            cnt_q    <= '0;
        end else begin
            req_q <= coin_req;
            for (int i = 0; i < 2; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (cnt_q[i] == CNT_W'(1)) begin
                        coin_n_q[i] <= 1'b1;
                    end
                end else if (coin_req[i] && !req_q[i]) begin
                    cnt_q[i]    <= PULSE_LOAD;
                    coin_n_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.coin1_n  = coin_n_q[0];
    assign bus.coin2_n  = coin_n_q[1];
    assign bus.start1_n = level_n_q[9];
    assign bus.start2_n = level_n_q[8];
    assign bus.up1_n    = level_n_q[7];
    assign bus.down1_n  = level_n_q[6];
    assign bus.left1_n  = level_n_q[5];
    assign bus.right1_n = level_n_q[4];
    assign bus.up2_n    = level_n_q[3];
    assign bus.down2_n  = level_n_q[2];
    assign bus.left2_n  = level_n_q[1];
    assign bus.right2_n = level_n_q[0];
endmodule

// File: tb/tb_dominos_inputs.sv
// Bench for dominos_inputs: directed key/joystick stimulus, a per-cycle behavioural model
// of the cabinet pins, and literal expectations for latency, pulse length and lockout.
module tb_dominos_inputs;
    localparam int N  = 16;
    localparam int CW = 5;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    dominos_inputs_if bus();

    dominos_inputs #(.COIN_PULSE_CYCLES(N), .CNT_W(CW)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {coin1, coin2, start1, start2, up1, down1, left1, right1, up2, down2, left2, right2}
    function automatic logic [11:0] dut_out();
        return {bus.coin1_n, bus.coin2_n, bus.start1_n, bus.start2_n,
                bus.up1_n, bus.down1_n, bus.left1_n, bus.right1_n,
                bus.up2_n, bus.down2_n, bus.left2_n, bus.right2_n};
    endfunction

    // Model: set of held key codes, last joystick words, and the start edge of each coin pulse.
    bit          m_held [256];
    logic [15:0] m_jq0, m_jq1;
    bit          m_armed, m_tog;
    bit          m_prev [2];
    int          m_start [2];
    int          m_edge = 0;
    logic [11:0] m_exp;

    function automatic bit is_arrow(input logic [7:0] c);
        return c inside {8'h75, 8'h72, 8'h6B, 8'h74};
    endfunction

    function automatic bit is_plain(input logic [7:0] c);
        return c inside {8'h29, 8'h2E, 8'h14, 8'h36, 8'h16, 8'h05,
                         8'h1E, 8'h06, 8'h2D, 8'h2B, 8'h23, 8'h34};
    endfunction

    task automatic m_clear();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_jq0 = '0;
        m_jq1 = '0;
        m_armed = 1'b0;
        m_tog = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_prev[c]  = 1'b0;
            m_start[c] = -1000;
        end
        m_exp = 12'hFFF;
    endtask

    task automatic m_step();
        bit u1, d1, l1, r1, u2, d2, l2, r2, s1, s2;
        bit req [2];
        bit low [2];
        logic [7:0] code;
        u1 = m_held[8'h75] | m_jq0[3];
        d1 = m_held[8'h72] | m_jq0[2];
        l1 = m_held[8'h6B] | m_jq0[1];
        r1 = m_held[8'h74] | m_jq0[0];
        u2 = m_held[8'h2D] | m_jq1[3];
        d2 = m_held[8'h2B] | m_jq1[2];
        l2 = m_held[8'h23] | m_jq1[1];
        r2 = m_held[8'h34] | m_jq1[0];
        s1 = m_held[8'h16] | m_held[8'h05] | m_jq0[5] | m_jq1[5];
        s2 = m_held[8'h1E] | m_held[8'h06] | m_jq0[6] | m_jq1[6];
        req[0] = m_held[8'h29] | m_held[8'h2E] | m_jq0[4];
        req[1] = m_held[8'h14] | m_held[8'h36] | m_jq1[4];
        for (int c = 0; c < 2; c++) begin
            // A new pulse may start only once the previous one has fully drained.
            if (req[c] && !m_prev[c] && m_edge >= m_start[c] + N + 1) m_start[c] = m_edge;
            m_prev[c] = req[c];
            low[c] = (m_edge >= m_start[c]) && (m_edge < m_start[c] + N);
        end
        m_exp = ~{low[0], low[1], s1, s2,
                  u1 & ~d1, d1 & ~u1, l1 & ~r1, r1 & ~l1,
                  u2 & ~d2, d2 & ~u2, l2 & ~r2, r2 & ~l2};
        m_edge++;
        code = bus.ps2_key[7:0];
        if (m_armed && (bus.ps2_key[10] != m_tog)) begin
            if (is_arrow(code) || (!bus.ps2_key[8] && is_plain(code))) m_held[code] = bus.ps2_key[9];
        end
        m_tog   = bus.ps2_key[10];
        m_armed = 1'b1;
        m_jq0   = bus.joystick_0;
        m_jq1   = bus.joystick_1;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk_sys or posedge reset);
            if (reset) m_clear();
            else m_step();
            #2;
            check("cycle_outputs", dut_out(), m_exp);
        end
    end

    task automatic key_event(input bit ext, input logic [7:0] code, input bit pressed);
        @(negedge clk_sys);
        bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic measure(input int n, output int low1, output int fall1,
                           output int low2, output int fall2);
        logic p1, p2;
        low1 = 0; fall1 = 0; low2 = 0; fall2 = 0;
        p1 = bus.coin1_n;
        p2 = bus.coin2_n;
        repeat (n) begin
            @(negedge clk_sys);
            if (!bus.coin1_n) low1++;
            if (!bus.coin2_n) low2++;
            if (p1 && !bus.coin1_n) fall1++;
            if (p2 && !bus.coin2_n) fall2++;
            p1 = bus.coin1_n;
            p2 = bus.coin2_n;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  l1, f1, l2, f2, t;
        bit  any_low;
        bus.ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        idle(3);
        reset = 1'b0;

        // Stale toggle level at reset release must not decode as a key.
        any_low = 1'b0;
        repeat (100) begin
            @(negedge clk_sys);
            if (dut_out() != 12'hFFF) any_low = 1'b1;
        end
        check("reset_quiet_100", any_low, 1'b0);
        key_event(1'b0, 8'h75, 1'b1);
        @(negedge clk_sys);
        check("up1_not_yet", bus.up1_n, 1'b1);
        @(negedge clk_sys);
        check("up1_pressed", bus.up1_n, 1'b0);
        key_event(1'b0, 8'h75, 1'b0);
        idle(2);
        check("up1_released", bus.up1_n, 1'b1);

        // Coin alias pair: releasing space while 5 is held gives a single pulse.
        fork
            measure(60, l1, f1, l2, f2);
            begin
                key_event(1'b0, 8'h29, 1'b1);
                key_event(1'b0, 8'h2E, 1'b1);
                key_event(1'b0, 8'h29, 1'b0);
            end
        join
        check("alias_low_cycles", l1, N);
        check("alias_pulse_count", f1, 1);
        measure(30, l1, f1, l2, f2);
        check("held_no_repulse", f1, 0);
        key_event(1'b0, 8'h2E, 1'b0);
        idle(2);
        fork
            measure(40, l1, f1, l2, f2);
            key_event(1'b0, 8'h2E, 1'b1);
        join
        check("repress_low_cycles", l1, N);
        check("repress_pulse_count", f1, 1);
        key_event(1'b0, 8'h2E, 1'b0);
        idle(3);

        // Retrigger while busy is dropped; coin2 runs concurrently.
        fork
            measure(50, l1, f1, l2, f2);
            begin
                @(negedge clk_sys);
                bus.joystick_0[4] = 1'b1;
                bus.joystick_1[4] = 1'b1;
                @(negedge clk_sys);
                bus.joystick_0[4] = 1'b0;
                @(negedge clk_sys);
                bus.joystick_0[4] = 1'b1;
                idle(4);
                check("coins_overlap", {bus.coin1_n, bus.coin2_n}, 2'b00);
            end
        join
        check("retrig_coin1_low", l1, N);
        check("retrig_coin1_count", f1, 1);
        check("coin2_low", l2, N);
        check("coin2_count", f2, 1);
        @(negedge clk_sys);
        bus.joystick_0[4] = 1'b0;
        bus.joystick_1[4] = 1'b0;
        idle(3);

        // Player 2 up/down lockout.
        @(negedge clk_sys);
        bus.joystick_1[3] = 1'b1;
        key_event(1'b0, 8'h2D, 1'b1);
        idle(2);
        check("up2_only", {bus.up2_n, bus.down2_n}, 2'b01);
        key_event(1'b0, 8'h2B, 1'b1);
        idle(2);
        check("lockout_both_high", {bus.up2_n, bus.down2_n}, 2'b11);
        key_event(1'b0, 8'h2B, 1'b0);
        idle(2);
        check("lockout_release_f", {bus.up2_n, bus.down2_n}, 2'b01);
        @(negedge clk_sys);
        bus.joystick_1[3] = 1'b0;
        idle(2);
        check("up2_key_still_held", bus.up2_n, 1'b0);
        key_event(1'b0, 8'h2D, 1'b0);
        idle(2);
        check("up2_released", bus.up2_n, 1'b1);

        // Extended prefix: ignored for ctrl, irrelevant for arrows.
        fork
            measure(30, l1, f1, l2, f2);
            key_event(1'b1, 8'h14, 1'b1);
        join
        check("ext_ctrl_no_coin", f2, 0);
        key_event(1'b1, 8'h14, 1'b0);
        fork
            measure(30, l1, f1, l2, f2);
            key_event(1'b0, 8'h14, 1'b1);
        join
        check("ctrl_coin2_low", l2, N);
        check("ctrl_coin2_count", f2, 1);
        key_event(1'b0, 8'h14, 1'b0);
        key_event(1'b1, 8'h6B, 1'b1);
        idle(2);
        check("ext_left1", bus.left1_n, 1'b0);
        key_event(1'b1, 8'h6B, 1'b0);
        idle(3);

        // Asynchronous reset mid-pulse with keys held.
        key_event(1'b0, 8'h75, 1'b1);
        key_event(1'b0, 8'h29, 1'b1);
        t = 0;
        while (bus.coin1_n && t < 10) begin
            @(negedge clk_sys);
            t++;
        end
        check("coin_start_seen", t < 10, 1'b1);
        idle(8);
        check("coin_mid_pulse", bus.coin1_n, 1'b0);
        #2 reset = 1'b1;
        #1 check("async_reset_all_high", dut_out(), 12'hFFF);
        idle(2);
        reset = 1'b0;
        any_low = 1'b0;
        repeat (30) begin
            @(negedge clk_sys);
            if (dut_out() != 12'hFFF) any_low = 1'b1;
        end
        check("post_reset_quiet", any_low, 1'b0);
        key_event(1'b0, 8'h75, 1'b1);
        idle(2);
        check("post_reset_new_event", bus.up1_n, 1'b0);
        key_event(1'b0, 8'h75, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
